// File: rtl/unidade_controle_pkg.sv
// State codes, output bundle and output decode for the sequence-memory game controller.
// Shared by the FSM, the interface and any top level that observes db_estado.
package unidade_controle_pkg;

  localparam int ESTADO_W_PADRAO = 5;

  localparam logic [4:0] INICIAL           = 5'h00;
  localparam logic [4:0] PREPARACAO        = 5'h01;
  localparam logic [4:0] MOSTRA_ON         = 5'h02;
  localparam logic [4:0] MOSTRA_OFF        = 5'h03;
  localparam logic [4:0] PROXIMO_LED       = 5'h04;
  localparam logic [4:0] INICIO_RODADA     = 5'h05;
  localparam logic [4:0] ESPERA_JOGADA     = 5'h06;
  localparam logic [4:0] REGISTRA          = 5'h07;
  localparam logic [4:0] COMPARACAO        = 5'h08;
  localparam logic [4:0] PROXIMO_ENDERECO  = 5'h09;
  localparam logic [4:0] PROXIMA_SEQUENCIA = 5'h0A;
  localparam logic [4:0] FIM_ACERTO        = 5'h0B;
  localparam logic [4:0] FIM_TIMEOUT       = 5'h0D;
  localparam logic [4:0] FIM_ERRO          = 5'h0E;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraS;
    logic contaS;
    logic zeraR;
    logic registraR;
    logic estadoEspera;
    logic estadoLedsOn;
    logic estadoLedsOff;
    logic pronto;
    logic acertou;
    logic errou;
  } sinais_t;

  // Moore decode: every control strobe is a pure function of the state code.
  function automatic sinais_t decodificaSaidas(input logic [4:0] estado);
    sinais_t s;
    s = '0;
    case (estado)
      PREPARACAO:        begin s.zeraE = 1'b1; s.zeraS = 1'b1; s.zeraR = 1'b1; end
      MOSTRA_ON:         s.estadoLedsOn = 1'b1;
      MOSTRA_OFF:        s.estadoLedsOff = 1'b1;
      PROXIMO_LED:       s.contaE = 1'b1;
      INICIO_RODADA:     begin s.zeraE = 1'b1; s.zeraR = 1'b1; end
      ESPERA_JOGADA:     s.estadoEspera = 1'b1;
      REGISTRA:          s.registraR = 1'b1;
      PROXIMO_ENDERECO:  s.contaE = 1'b1;
      PROXIMA_SEQUENCIA: begin s.contaS = 1'b1; s.zeraE = 1'b1; end
      FIM_ACERTO:        begin s.pronto = 1'b1; s.acertou = 1'b1; end
      FIM_TIMEOUT,
      FIM_ERRO:          begin s.pronto = 1'b1; s.errou = 1'b1; end
      default:           s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Status/control bundle between the game controller (master) and its datapath (slave).
interface unidade_controle_if #(
  parameter int ESTADO_W = 5
);
  logic iniciar;
  logic jogadaIgualMemoria;
  logic enderecoIgualSequencia;
  logic tem_jogada;
  logic fimS;
  logic fimLedsOn;
  logic fimLedsOff;
  logic timeout;

  logic zeraE;
  logic contaE;
  logic zeraS;
  logic contaS;
  logic zeraR;
  logic registraR;
  logic estado_espera;
  logic estado_ledsOn;
  logic estado_ledsOff;
  logic pronto;
  logic acertou;
  logic errou;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    input  iniciar, jogadaIgualMemoria, enderecoIgualSequencia, tem_jogada,
           fimS, fimLedsOn, fimLedsOff, timeout,
    output zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera,
           estado_ledsOn, estado_ledsOff, pronto, acertou, errou, db_estado
  );

  modport slave (
    output iniciar, jogadaIgualMemoria, enderecoIgualSequencia, tem_jogada,
           fimS, fimLedsOn, fimLedsOff, timeout,
    input  zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera,
           estado_ledsOn, estado_ledsOff, pronto, acertou, errou, db_estado
  );
endinterface

// File: rtl/unidade_controle.sv
// Moore FSM sequencing the sequence-memory game: replay, collect plays, verdict.
// Define UNIDADE_CONTROLE_TIMEOUT_EN to let espera_jogada end the game on timeout.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int ESTADO_W = ESTADO_W_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  unidade_controle_if.master uc
);

  logic [4:0] estado_reg;
  logic [4:0] estado_next;
  sinais_t    saidas;

  always_ff @(posedge clock) begin
    if (reset) estado_reg <= INICIAL;
    else       estado_reg <= estado_next;
  end

  always_comb begin
    estado_next = INICIAL;
    case (estado_reg)
      INICIAL:       estado_next = uc.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    estado_next = MOSTRA_ON;
      MOSTRA_ON:     estado_next = uc.fimLedsOn ? MOSTRA_OFF : MOSTRA_ON;
      MOSTRA_OFF: begin
        if (!uc.fimLedsOff)                estado_next = MOSTRA_OFF;
        else if (uc.enderecoIgualSequencia) estado_next = INICIO_RODADA;
        else                               estado_next = PROXIMO_LED;
      end
      PROXIMO_LED:   estado_next = MOSTRA_ON;
      INICIO_RODADA: estado_next = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A key press in the same cycle as the timeout still counts as a play.
        if (uc.tem_jogada) estado_next = REGISTRA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        else if (uc.timeout) estado_next = FIM_TIMEOUT;
`endif
        else estado_next = ESPERA_JOGADA;
      end
      REGISTRA:      estado_next = COMPARACAO;
      COMPARACAO: begin
        if (!uc.jogadaIgualMemoria)         estado_next = FIM_ERRO;
        else if (uc.fimS)                   estado_next = FIM_ACERTO;
        else if (uc.enderecoIgualSequencia) estado_next = PROXIMA_SEQUENCIA;
        else                                estado_next = PROXIMO_ENDERECO;
      end
      PROXIMO_ENDERECO:  estado_next = ESPERA_JOGADA;
      PROXIMA_SEQUENCIA: estado_next = MOSTRA_ON;
      FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
        estado_next = uc.iniciar ? PREPARACAO : estado_reg;
      default:       estado_next = INICIAL;
    endcase
  end

`ifndef UNIDADE_CONTROLE_TIMEOUT_EN
  logic unusedTimeout;
  assign unusedTimeout = uc.timeout;
`endif

  assign saidas = decodificaSaidas(estado_reg);

  assign uc.zeraE          = saidas.zeraE;
  assign uc.contaE         = saidas.contaE;
  assign uc.zeraS          = saidas.zeraS;
  assign uc.contaS         = saidas.contaS;
  assign uc.zeraR          = saidas.zeraR;
  assign uc.registraR      = saidas.registraR;
  assign uc.estado_espera  = saidas.estadoEspera;
  assign uc.estado_ledsOn  = saidas.estadoLedsOn;
  assign uc.estado_ledsOff = saidas.estadoLedsOff;
  assign uc.pronto         = saidas.pronto;
  assign uc.acertou        = saidas.acertou;
  assign uc.errou          = saidas.errou;
  assign uc.db_estado      = ESTADO_W'(estado_reg);

endmodule

// File: tb/tb_unidade_controle.sv
// Directed game scenarios followed by random input traffic, checked against a
// behavioural model of the game controller written from the state-code table.
module tb_unidade_controle;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  unidade_controle_if #(.ESTADO_W(5)) ifc ();

  unidade_controle #(.ESTADO_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .uc    (ifc.master)
  );

  // Stimulus bit positions inside a step word.
  localparam int B_INI = 0, B_JIM = 1, B_EIS = 2, B_TJ = 3, B_FS = 4,
                 B_LON = 5, B_LOFF = 6, B_TO = 7, B_RST = 8;
  localparam logic [8:0] INI = 9'h001, JIM = 9'h002, EIS = 9'h004, TJ = 9'h008,
                         FS = 9'h010, LON = 9'h020, LOFF = 9'h040, TOUT = 9'h080,
                         RST = 9'h100, NADA = 9'h000;

  // Output vector order: zeraE contaE zeraS contaS zeraR registraR espera ledsOn ledsOff pronto acertou errou
  localparam logic [11:0] O_ZE = 12'h800, O_CE = 12'h400, O_ZS = 12'h200, O_CS = 12'h100,
                          O_ZR = 12'h080, O_RR = 12'h040, O_ESP = 12'h020, O_LON = 12'h010,
                          O_LOFF = 12'h008, O_PR = 12'h004, O_AC = 12'h002, O_ER = 12'h001;

  int vectors = 0;
  int miscompares = 0;
  int modelo = 0;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Game rules: where the controller goes from a given phase under given inputs.
  function automatic int regraProximo(input int e, input logic [8:0] in);
    if (in[B_RST]) return 0;
    if (e == 'h00) return in[B_INI] ? 'h01 : 'h00;
    if (e == 'h01) return 'h02;
    if (e == 'h02) return in[B_LON] ? 'h03 : 'h02;
    if (e == 'h03) return !in[B_LOFF] ? 'h03 : (in[B_EIS] ? 'h05 : 'h04);
    if (e == 'h04) return 'h02;
    if (e == 'h05) return 'h06;
    if (e == 'h06) begin
      if (in[B_TJ]) return 'h07;
      if (TIMEOUT_EN && in[B_TO]) return 'h0D;
      return 'h06;
    end
    if (e == 'h07) return 'h08;
    if (e == 'h08) begin
      if (!in[B_JIM]) return 'h0E;
      if (in[B_FS]) return 'h0B;
      return in[B_EIS] ? 'h0A : 'h09;
    end
    if (e == 'h09) return 'h06;
    if (e == 'h0A) return 'h02;
    if (e == 'h0B || e == 'h0D || e == 'h0E) return in[B_INI] ? 'h01 : e;
    return 0;
  endfunction

  function automatic logic [11:0] regraSaidas(input int e);
    logic [11:0] tabela [0:15];
    for (int i = 0; i < 16; i++) tabela[i] = '0;
    tabela[1]  = O_ZE | O_ZS | O_ZR;
    tabela[2]  = O_LON;
    tabela[3]  = O_LOFF;
    tabela[4]  = O_CE;
    tabela[5]  = O_ZE | O_ZR;
    tabela[6]  = O_ESP;
    tabela[7]  = O_RR;
    tabela[9]  = O_CE;
    tabela[10] = O_CS | O_ZE;
    tabela[11] = O_PR | O_AC;
    tabela[13] = O_PR | O_ER;
    tabela[14] = O_PR | O_ER;
    return tabela[e[3:0]];
  endfunction

  function automatic logic [11:0] saidasDut();
    return {ifc.zeraE, ifc.contaE, ifc.zeraS, ifc.contaS, ifc.zeraR, ifc.registraR,
            ifc.estado_espera, ifc.estado_ledsOn, ifc.estado_ledsOff,
            ifc.pronto, ifc.acertou, ifc.errou};
  endfunction

  task automatic compara(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vectors++;
    assert (obs === esp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  // One clock: drive inputs, advance the model, check state code and outputs after the edge.
  task automatic passo(input logic [8:0] in);
    reset                      = in[B_RST];
    ifc.iniciar                = in[B_INI];
    ifc.jogadaIgualMemoria     = in[B_JIM];
    ifc.enderecoIgualSequencia = in[B_EIS];
    ifc.tem_jogada             = in[B_TJ];
    ifc.fimS                   = in[B_FS];
    ifc.fimLedsOn              = in[B_LON];
    ifc.fimLedsOff             = in[B_LOFF];
    ifc.timeout                = in[B_TO];
    modelo = regraProximo(modelo, in);
    @(posedge clock);
    #1;
    compara("db_estado", 32'(ifc.db_estado), 32'(modelo));
    compara("saidas", 32'(saidasDut()), 32'(regraSaidas(modelo)));
    $display("step in=%03h estado=%02h saidas=%03h", in, ifc.db_estado, saidasDut());
  endtask

  task automatic codigo(input string tag, input logic [4:0] esp);
    compara(tag, 32'(ifc.db_estado), 32'(esp));
  endtask

  // From preparacao through a single-LED replay into espera_jogada.
  task automatic ateEspera();
    passo(NADA);       codigo("prep_to_on", 5'h02);
    passo(LON);        codigo("on_to_off", 5'h03);
    passo(LOFF | EIS); codigo("off_to_rodada", 5'h05);
    passo(NADA);       codigo("rodada_to_espera", 5'h06);
  endtask

  initial begin
    logic [8:0] r;
    passo(RST);
    codigo("reset_estado", 5'h00);
    compara("reset_saidas", 32'(saidasDut()), 32'h0);

    // Reset asserted mid-game from espera_jogada.
    passo(INI); codigo("inicial_to_prep", 5'h01);
    ateEspera();
    passo(RST | TJ); codigo("reset_mid", 5'h00);
    compara("reset_mid_saidas", 32'(saidasDut()), 32'h0);
    passo(NADA); codigo("inicial_hold", 5'h00);

    // Round 0: one correct play on the last address.
    passo(INI); codigo("r0_prep", 5'h01);
    compara("r0_zeros", 32'({ifc.zeraE, ifc.zeraS, ifc.zeraR}), 32'h7);
    ateEspera();
    passo(TJ);        codigo("r0_registra", 5'h07);
    passo(NADA);      codigo("r0_comparacao", 5'h08);
    passo(JIM | EIS); codigo("r0_proxseq", 5'h0A);
    compara("r0_contaS", 32'(ifc.contaS), 32'h1);

    // Round 1 replay: two LEDs.
    passo(NADA);       codigo("r1_on0", 5'h02);
    passo(LON);        codigo("r1_off0", 5'h03);
    passo(LOFF);       codigo("r1_proxled", 5'h04);
    compara("r1_contaE", 32'(ifc.contaE), 32'h1);
    passo(NADA);       codigo("r1_on1", 5'h02);
    passo(LOFF);       codigo("r1_on_hold", 5'h02);
    passo(LON);        codigo("r1_off1", 5'h03);
    passo(EIS);        codigo("r1_off_hold", 5'h03);
    passo(LOFF | EIS); codigo("r1_rodada", 5'h05);
    passo(NADA);       codigo("r1_espera", 5'h06);
    passo(TJ);         codigo("r1_reg0", 5'h07);
    passo(NADA);       codigo("r1_cmp0", 5'h08);
    passo(JIM);        codigo("r1_proxend", 5'h09);
    passo(NADA);       codigo("r1_espera1", 5'h06);

    // Simultaneous play and timeout: the play wins; then a wrong play.
    passo(TJ | TOUT);  codigo("tj_wins", 5'h07);
    passo(NADA);       codigo("cmp_erro", 5'h08);
    passo(EIS);        codigo("fim_erro", 5'h0E);
    compara("erro_flags", 32'({ifc.pronto, ifc.acertou, ifc.errou}), 32'h5);
    passo(NADA);       codigo("erro_hold", 5'h0E);
    passo(INI);        codigo("erro_restart", 5'h01);

    // Timeout in espera_jogada.
    ateEspera();
    passo(TOUT);
    codigo("timeout", TIMEOUT_EN ? 5'h0D : 5'h06);
    if (TIMEOUT_EN) passo(INI);
    else            passo(RST);
    passo(INI);
    ateEspera();

    // Last round won.
    passo(TJ);        codigo("last_reg", 5'h07);
    passo(NADA);      codigo("last_cmp", 5'h08);
    passo(JIM | FS);  codigo("fim_acerto", 5'h0B);
    compara("acerto_flags", 32'({ifc.pronto, ifc.acertou, ifc.errou}), 32'h6);
    passo(TJ | JIM);  compara("acertou_hold", 32'(ifc.acertou), 32'h1);
    passo(INI);       codigo("acerto_restart", 5'h01);

    // Random traffic; reset rare, timers and plays frequent.
    for (int i = 0; i < 600; i++) begin
      r = 9'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) r[B_RST] = 1'b1;
      if ($urandom_range(0, 3) != 0) r[B_JIM] = 1'b1;
      passo(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
